spi_reg_slave: RTL and testbench

SPI mode-0 responder with a small 8-bit register bank, clocked by the system clock and oversampling the SPI pins. It decodes two-byte command frames from the SPI master. Writes update the register bank, and reads shift the addressed register back on miso. It sits on the slave side of the SPI link, alongside the master in the top level, and exposes the register bank to the rest of the design (e.g. FND/LED logic).

---
 rtl/spi_reg_slave_if.sv | 24 ++
 rtl/spi_reg_slave.sv | 144 ++++++++++++++
 tb/tb_spi_reg_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle plus the register-bank side outputs of spi_reg_slave.
// The master modport is the view of the SPI master and of logic reading the bank.
interface spi_reg_slave_if #(
  parameter int ADDR_W = 2
);
  logic                        sclk;
  logic                        mosi;
  logic                        cs_n;
  logic                        miso;
  logic [8*(2**ADDR_W)-1:0]    regs;
  logic                        wr_strobe;
  logic [ADDR_W-1:0]           wr_addr;
  logic                        busy;

  modport master (
    output sclk, mosi, cs_n,
    input  miso, regs, wr_strobe, wr_addr, busy
  );

  modport slave (
    input  sclk, mosi, cs_n,
    output miso, regs, wr_strobe, wr_addr, busy
  );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-bank responder, oversampling the SPI pins on clk.
// Frame: command byte (bit7 = write, low bits = address), then one data byte.
module spi_reg_slave #(
  parameter int ADDR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_reg_slave_if.slave   spi
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic              r_mosi_s1, r_mosi_s2;
  logic              r_cs_s1, r_cs_s2;
  logic              r_rise, r_fall;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [6:0]        r_shift;
  logic [6:0]        r_sout;
  logic              r_cmd_full;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [8*NREG-1:0] r_regs;
  logic              r_miso;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_busy;

  logic [7:0]        w_shift_nx;

  assign w_shift_nx = {r_shift, r_mosi_s2};

  // Pin synchronizers; edge pulses are registered, so pin-to-pulse is 3 clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sclk_s1 <= spi.sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= spi.mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_cs_s1   <= spi.cs_n;
      r_cs_s2   <= r_cs_s1;
      r_rise    <= r_sclk_s2 & ~r_sclk_d;
      r_fall    <= ~r_sclk_s2 & r_sclk_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= 7'd0;
      r_sout      <= 7'd0;
      r_cmd_full  <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_regs      <= '0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      // Deselect has priority over everything, including a same-cycle final rise.
      if (r_cs_s2) begin
        r_state    <= IDLE;
        r_cnt      <= 3'd0;
        r_cmd_full <= 1'b0;
        r_miso     <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= CMD;
            r_cnt      <= 3'd0;
            r_cmd_full <= 1'b0;
            r_busy     <= 1'b1;
          end
          CMD: begin
            if (r_rise) begin
              r_shift <= w_shift_nx[6:0];
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                r_rw       <= w_shift_nx[7];
                r_addr     <= w_shift_nx[ADDR_W-1:0];
                r_cmd_full <= 1'b1;
              end
            end else if (r_fall && r_cmd_full) begin
              r_state    <= DATA;
              r_cmd_full <= 1'b0;
              if (!r_rw) begin
                r_sout <= r_regs[{r_addr, 3'b000} +: 7];
                r_miso <= r_regs[{r_addr, 3'b111}];
              end
            end
          end
          DATA: begin
            if (r_rise) begin
              r_shift <= w_shift_nx[6:0];
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                if (r_rw) begin
                  r_regs[{r_addr, 3'b000} +: 8] <= w_shift_nx;
                  r_wr_strobe <= 1'b1;
                  r_wr_addr   <= r_addr;
                end
                r_miso  <= 1'b0;
                r_state <= DONE;
              end
            end else if (r_fall && !r_rw) begin
              r_miso <= r_sout[6];
              r_sout <= {r_sout[5:0], 1'b0};
            end
          end
          DONE: begin
            r_miso <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign spi.miso      = r_miso;
  assign spi.regs      = r_regs;
  assign spi.wr_strobe = r_wr_strobe;
  assign spi.wr_addr   = r_wr_addr;
  assign spi.busy      = r_busy;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed vector table, hand-written corner sequences,
// and random frames checked against an array model of the register bank.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_reg_slave_if #(.ADDR_W(2)) spi ();

  spi_reg_slave #(.ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .spi (spi)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int stb_cnt = 0;
  logic [1:0] stb_addr = 2'd0;
  logic [7:0] mdl [4];

  always @(negedge clk) begin
    if (spi.wr_strobe === 1'b1) begin
      stb_cnt++;
      stb_addr = spi.wr_addr;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  dat;
    int          dbits;
    logic [7:0]  exp_rx;
    int          exp_stb;
    logic [31:0] exp_regs;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_flat();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < n; i++) begin
      spi.mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b1;
      rx = {rx[6:0], spi.miso};
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int cbits,
                       input int dbits, input int xbytes,
                       output logic [7:0] rx, output logic [7:0] rx_x);
    logic [7:0] junk;
    logic [7:0] t;
    rx   = 8'd0;
    rx_x = 8'd0;
    spi.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(cmd, cbits, junk);
    if (dbits > 0) spi_bits(dat, dbits, rx);
    for (int k = 0; k < xbytes; k++) begin
      spi_bits(8'hFF, 8, t);
      rx_x = rx_x | t;
    end
    repeat (4) @(negedge clk);
    spi.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx, rx_x, junk, cmd, dat;
    int s0, cbits, dbits;
    bit full;

    vecs[0] = '{8'h82, 8'hA5, 8, 8'h00, 1, 32'h00A5_0000};
    vecs[1] = '{8'h02, 8'h00, 8, 8'hA5, 0, 32'h00A5_0000};
    vecs[2] = '{8'h03, 8'h00, 8, 8'h00, 0, 32'h00A5_0000};
    vecs[3] = '{8'h81, 8'hFF, 4, 8'h00, 0, 32'h00A5_0000};
    vecs[4] = '{8'h81, 8'h5A, 8, 8'h00, 1, 32'h00A5_5A00};
    vecs[5] = '{8'h01, 8'h00, 8, 8'h5A, 0, 32'h00A5_5A00};
    vecs[6] = '{8'h7E, 8'h00, 8, 8'hA5, 0, 32'h00A5_5A00};
    vecs[7] = '{8'h83, 8'hC3, 8, 8'h00, 1, 32'hC3A5_5A00};
    vecs[8] = '{8'h03, 8'h00, 8, 8'hC3, 0, 32'hC3A5_5A00};

    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    spi.cs_n = 1'b1;

    repeat (3) @(negedge clk);
    check("reset miso", {31'd0, spi.miso}, 32'd0);
    check("reset regs", spi.regs, 32'd0);
    check("reset wr_strobe", {31'd0, spi.wr_strobe}, 32'd0);
    check("reset wr_addr", {30'd0, spi.wr_addr}, 32'd0);
    check("reset busy", {31'd0, spi.busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      s0 = stb_cnt;
      frame(vecs[i].cmd, vecs[i].dat, 8, vecs[i].dbits, 0, rx, rx_x);
      if (vecs[i].dbits == 8) check($sformatf("vec%0d rx", i), {24'd0, rx}, {24'd0, vecs[i].exp_rx});
      check($sformatf("vec%0d strobes", i), stb_cnt - s0, vecs[i].exp_stb);
      check($sformatf("vec%0d regs", i), spi.regs, vecs[i].exp_regs);
      if (vecs[i].exp_stb == 1) check($sformatf("vec%0d wr_addr", i), {30'd0, stb_addr}, {30'd0, vecs[i].cmd[1:0]});
      check($sformatf("vec%0d idle miso", i), {31'd0, spi.miso}, 32'd0);
    end
    for (int i = 0; i < 4; i++) mdl[i] = vecs[8].exp_regs[8*i +: 8];

    // Abort mid-data with busy timing on both cs_n edges
    s0 = stb_cnt;
    spi.cs_n = 1'b0;
    repeat (2) @(negedge clk);
    check("busy before rise", {31'd0, spi.busy}, 32'd0);
    @(negedge clk);
    check("busy rise 3clk", {31'd0, spi.busy}, 32'd1);
    spi_bits(8'h81, 8, junk);
    spi_bits(8'hFF, 4, junk);
    repeat (4) @(negedge clk);
    spi.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("busy before fall", {31'd0, spi.busy}, 32'd1);
    @(negedge clk);
    check("busy fall 3clk", {31'd0, spi.busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort strobes", stb_cnt - s0, 32'd0);
    check("abort regs", spi.regs, mdl_flat());

    // Overrun: third byte ignored, miso quiet
    s0 = stb_cnt;
    frame(8'h80, 8'h3C, 8, 8, 1, rx, rx_x);
    mdl[0] = 8'h3C;
    check("overrun strobes", stb_cnt - s0, 32'd1);
    check("overrun regs", spi.regs, mdl_flat());
    check("overrun miso byte3", {24'd0, rx_x}, 32'd0);

    // Random frames against the array model
    for (int it = 0; it < 24; it++) begin
      cmd = 8'($urandom);
      dat = 8'($urandom);
      full = ($urandom_range(0, 3) != 0);
      cbits = 8;
      dbits = 8;
      if (!full) begin
        cbits = $urandom_range(1, 8);
        dbits = (cbits == 8) ? $urandom_range(0, 7) : 0;
      end
      s0 = stb_cnt;
      frame(cmd, dat, cbits, dbits, 0, rx, rx_x);
      if (full && cmd[7]) begin
        mdl[cmd[1:0]] = dat;
        check($sformatf("rnd%0d strobes", it), stb_cnt - s0, 32'd1);
        check($sformatf("rnd%0d wr_addr", it), {30'd0, stb_addr}, {30'd0, cmd[1:0]});
      end else begin
        check($sformatf("rnd%0d strobes", it), stb_cnt - s0, 32'd0);
      end
      if (full && !cmd[7]) check($sformatf("rnd%0d rx", it), {24'd0, rx}, {24'd0, mdl[cmd[1:0]]});
      check($sformatf("rnd%0d regs", it), spi.regs, mdl_flat());
    end

    // Ensure addr 1 is non-zero, then reset during a write's data phase
    frame(8'h81, 8'h77, 8, 8, 0, rx, rx_x);
    mdl[1] = 8'h77;
    check("pre-reset regs", spi.regs, mdl_flat());
    spi.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h81, 8, junk);
    spi_bits(8'h55, 4, junk);
    rst = 1'b1;
    @(negedge clk);
    check("reset mid-frame regs", spi.regs, 32'd0);
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    repeat (5) @(negedge clk);
    check("busy after reset", {31'd0, spi.busy}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      s0 = stb_cnt;
      cmd = 8'(a);
      frame(cmd, 8'h00, 8, 8, 0, rx, rx_x);
      check($sformatf("post-reset read%0d", a), {24'd0, rx}, 32'd0);
      check($sformatf("post-reset read%0d strobes", a), stb_cnt - s0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
